opb_master: RTL and testbench
=============================

# opb_master

Single-outstanding OPB bus initiator that turns host-side request/response handshakes into the one-cycle DEC_RE/DEC_WE strobes, DEC_ADDR and DEC_DI consumed by the OPB address decoder. It captures the decoder's registered read-data return on DEC_DO and hands it back to the host. It sits between the host-interface logic (SPI/MCU front end) and the decoder, and is the only driver of the decode bus.

## Interface
Parameters:
- READ_LAT, 1: cycles from DEC_RE high to the cycle in which DEC_DO is sampled. Legal range 1..15; the decoder's registered return path needs 1.
- CHECK_ALIGN, 1: when 1, a request with ADDR[1:0] != 0 is rejected with an error and no bus strobe.

Ports (clock and reset first):
- OPB_CLK  in  1  bus clock; the only clock.
- OPB_RST_N  in  1  reset; asynchronous assert, active-low.
- HOST_REQ_VALID  in  1  request present.
- HOST_REQ_READY  out  1  block can accept a request.
- HOST_REQ_WR  in  1  1 = write, 0 = read.
- HOST_REQ_ADDR  in  32  byte address.
- HOST_REQ_WDATA  in  32  write data.
- HOST_RSP_VALID  out  1  response present.
- HOST_RSP_READY  in  1  host accepts the response.
- HOST_RSP_RDATA  out  32  read data; 0 for writes and errors.
- HOST_RSP_ERR  out  1  misaligned request rejected.
- DEC_RE  out  1  read strobe, one cycle.
- DEC_WE  out  1  write strobe, one cycle.
- DEC_ADDR  out  32  bus address.
- DEC_DI  out  32  bus write data.
- DEC_DO  in  32  decoder read return.

## Operation
- States: IDLE, WRITE, READ, WAIT, RESP.
- Request handshake: a request is accepted when HOST_REQ_VALID and HOST_REQ_READY are both high at a clock edge. HOST_REQ_READY is high only in IDLE.
- On accept, ADDR, WDATA and WR are registered into DEC_ADDR and DEC_DI.
  - DEC_DI is loaded only for writes.
  - Both hold their values until the next accepted request.
- Next state after accept:
  - misaligned request with CHECK_ALIGN=1: RESP, with ERR=1.
  - otherwise a write: WRITE.
  - otherwise a read: READ.
- WRITE: DEC_WE=1 for exactly this cycle, then RESP with RDATA=0 and ERR=0.
- READ: DEC_RE=1 for exactly this cycle, then WAIT.
- WAIT: a down-counter is loaded with READ_LAT-1.
  - On the edge where the counter reads 0, DEC_DO is latched into HOST_RSP_RDATA and the state moves to RESP.
- RESP: HOST_RSP_VALID=1. RDATA and ERR are held stable until HOST_RSP_READY is high at an edge, then the state returns to IDLE.
- DEC_RE and DEC_WE are register outputs and are never high together. Only one transaction is ever outstanding.
- Reads of unmapped addresses return whatever DEC_DO carries; no error is flagged.

## Timing
- Reset values of outputs:
  - HOST_REQ_READY=0, HOST_RSP_VALID=0, HOST_RSP_RDATA=0, HOST_RSP_ERR=0.
  - DEC_RE=0, DEC_WE=0, DEC_ADDR=0, DEC_DI=0.
  - State is IDLE. HOST_REQ_READY goes to 1 on the first edge after OPB_RST_N deasserts.
- Cycle numbering: request accepted at edge ending cycle N.
  - Write: DEC_WE high in cycle N+1; HOST_RSP_VALID high from N+2.
  - Read: DEC_RE high in N+1; DEC_DO sampled at end of cycle N+1+READ_LAT; HOST_RSP_VALID high from N+2+READ_LAT.
  - Misaligned: no strobe; HOST_RSP_VALID high from N+1.
- Response handshake at end of cycle M: HOST_RSP_VALID is 0 and HOST_REQ_READY is 1 in M+1. The next request can be accepted at the end of M+1.
- Back-to-back throughput with HOST_RSP_READY tied high:
  - writes: one every 3 cycles.
  - reads: one every 3+READ_LAT cycles.
- Reset asserted mid-transaction: all outputs take their reset values immediately (asynchronously). The in-flight transaction is discarded; no response and no strobe are produced after release.
- HOST_REQ_* inputs are ignored outside IDLE. HOST_RSP_READY is ignored outside RESP.

## Test plan
- Write: ADDR=0x40, WDATA=0xA5A5_5A5A accepted at N -> DEC_WE=1 only in N+1 with DEC_ADDR=0x40 and DEC_DI=0xA5A5_5A5A; RSP_VALID at N+2 with RDATA=0, ERR=0.
- Read with READ_LAT=1: ADDR=0x100, decoder model drives DEC_DO=0x1234_5678 in the cycle after DEC_RE -> DEC_RE=1 only in N+1; RSP_VALID at N+3 with RDATA=0x1234_5678.
- Backpressure: hold HOST_RSP_READY=0 for 5 cycles during RESP -> RSP_VALID and RDATA stay stable, REQ_READY stays 0, no strobes; after the handshake, REQ_READY=1 on the next cycle.
- Misaligned: ADDR=0x42 with CHECK_ALIGN=1 -> no DEC_RE/DEC_WE; RSP_VALID at N+1 with ERR=1, RDATA=0. Same address with CHECK_ALIGN=0 -> normal read strobe.
- Reset mid-read: READ_LAT=4, assert OPB_RST_N=0 in the second WAIT cycle -> all outputs are 0 immediately; after release, REQ_READY=1 on the first edge and no stale RSP_VALID appears.
- Streaming: 4 alternating writes/reads with VALID and RSP_READY held high -> strobe spacing of 3 cycles for writes and 4 cycles for reads (READ_LAT=1); never more than one strobe outstanding; data matches the scoreboard.

Source files
------------

// File: rtl/opb_master.sv
// Single-outstanding OPB initiator: converts host request/response handshakes
// into one-cycle decoder strobes and returns the decoder's registered read data.
module opb_master #(
  parameter int READ_LAT    = 1,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic        HOST_REQ_VALID,
  output logic        HOST_REQ_READY,
  input  logic        HOST_REQ_WR,
  input  logic [31:0] HOST_REQ_ADDR,
  input  logic [31:0] HOST_REQ_WDATA,
  output logic        HOST_RSP_VALID,
  input  logic        HOST_RSP_READY,
  output logic [31:0] HOST_RSP_RDATA,
  output logic        HOST_RSP_ERR,
  output logic        DEC_RE,
  output logic        DEC_WE,
  output logic [31:0] DEC_ADDR,
  output logic [31:0] DEC_DI,
  input  logic [31:0] DEC_DO
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_e;

  localparam logic [3:0] LAT_LOAD = 4'(READ_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] di_q, di_d;

  logic accept;
  logic misaligned;
  logic cnt_done;

  assign accept     = ready_q && HOST_REQ_VALID;
  assign misaligned = CHECK_ALIGN && (HOST_REQ_ADDR[1:0] != 2'b00);
  assign cnt_done   = (cnt_q == 4'd0);

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      di_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      re_q        <= re_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned)       state_d = RESP;
          else if (HOST_REQ_WR) state_d = WRITE;
          else                  state_d = READ;
        end
      end
      WRITE:   state_d = RESP;
      READ:    state_d = WAIT;
      WAIT:    if (cnt_done) state_d = RESP;
      RESP:    if (HOST_RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every visible output is a register, so its next value is decoded from state_d.
  always_comb begin
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    we_d        = (state_d == WRITE);
    re_d        = (state_d == READ);
    addr_d      = addr_q;
    di_d        = di_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    if (state_q == IDLE && accept) begin
      addr_d  = HOST_REQ_ADDR;
      rdata_d = 32'd0;
      err_d   = misaligned;
      if (HOST_REQ_WR) di_d = HOST_REQ_WDATA;
    end

    if (state_q == READ) cnt_d = LAT_LOAD;

    if (state_q == WAIT) begin
      if (cnt_done) rdata_d = DEC_DO;
      else          cnt_d   = cnt_q - 4'd1;
    end
  end

  assign HOST_REQ_READY = ready_q;
  assign HOST_RSP_VALID = rsp_valid_q;
  assign HOST_RSP_RDATA = rdata_q;
  assign HOST_RSP_ERR   = err_q;
  assign DEC_RE         = re_q;
  assign DEC_WE         = we_q;
  assign DEC_ADDR       = addr_q;
  assign DEC_DI         = di_q;

endmodule

// File: tb/tb_opb_master.sv
// Directed bench for opb_master: two instances (READ_LAT=1/aligned-check and
// READ_LAT=4/no-check), each talking to a small registered decoder model.
module tb_opb_master;

  logic        clk;
  logic        rstN      [2];
  logic        reqValid  [2];
  logic        reqReady  [2];
  logic        reqWr     [2];
  logic [31:0] reqAddr   [2];
  logic [31:0] reqWdata  [2];
  logic        rspValid  [2];
  logic        rspReady  [2];
  logic [31:0] rspRdata  [2];
  logic        rspErr    [2];
  logic        decRe     [2];
  logic        decWe     [2];
  logic [31:0] decAddr   [2];
  logic [31:0] decDi     [2];
  logic [31:0] decDo     [2];

  logic [31:0] mem [2][256];
  logic [31:0] sb  [2][256];

  int vecCount;
  int missCount;
  int cyc = 0;

  opb_master #(.READ_LAT(1), .CHECK_ALIGN(1'b1)) dutA (
    .OPB_CLK(clk), .OPB_RST_N(rstN[0]),
    .HOST_REQ_VALID(reqValid[0]), .HOST_REQ_READY(reqReady[0]),
    .HOST_REQ_WR(reqWr[0]), .HOST_REQ_ADDR(reqAddr[0]), .HOST_REQ_WDATA(reqWdata[0]),
    .HOST_RSP_VALID(rspValid[0]), .HOST_RSP_READY(rspReady[0]),
    .HOST_RSP_RDATA(rspRdata[0]), .HOST_RSP_ERR(rspErr[0]),
    .DEC_RE(decRe[0]), .DEC_WE(decWe[0]), .DEC_ADDR(decAddr[0]),
    .DEC_DI(decDi[0]), .DEC_DO(decDo[0])
  );

  opb_master #(.READ_LAT(4), .CHECK_ALIGN(1'b0)) dutB (
    .OPB_CLK(clk), .OPB_RST_N(rstN[1]),
    .HOST_REQ_VALID(reqValid[1]), .HOST_REQ_READY(reqReady[1]),
    .HOST_REQ_WR(reqWr[1]), .HOST_REQ_ADDR(reqAddr[1]), .HOST_REQ_WDATA(reqWdata[1]),
    .HOST_RSP_VALID(rspValid[1]), .HOST_RSP_READY(rspReady[1]),
    .HOST_RSP_RDATA(rspRdata[1]), .HOST_RSP_ERR(rspErr[1]),
    .DEC_RE(decRe[1]), .DEC_WE(decWe[1]), .DEC_ADDR(decAddr[1]),
    .DEC_DI(decDi[1]), .DEC_DO(decDo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] initWord(input int i);
    return (i == 64) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(i));
  endfunction

  // Registered decoder: read data appears the cycle after DEC_RE; memory reloads in reset.
  for (genvar g = 0; g < 2; g++) begin : g_dec
    always @(posedge clk) begin
      if (!rstN[g]) begin
        for (int i = 0; i < 256; i++) mem[g][i] <= initWord(i);
        decDo[g] <= 32'd0;
      end else begin
        if (decWe[g]) mem[g][decAddr[g][9:2]] <= decDi[g];
        if (decRe[g]) decDo[g] <= mem[g][decAddr[g][9:2]];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input int d, input string tag);
    checkOutput({tag, "/reqReady"}, 32'(reqReady[d]), 0);
    checkOutput({tag, "/rspValid"}, 32'(rspValid[d]), 0);
    checkOutput({tag, "/rdata"},    rspRdata[d],       0);
    checkOutput({tag, "/err"},      32'(rspErr[d]),   0);
    checkOutput({tag, "/re"},       32'(decRe[d]),    0);
    checkOutput({tag, "/we"},       32'(decWe[d]),    0);
    checkOutput({tag, "/addr"},     decAddr[d],        0);
    checkOutput({tag, "/di"},       decDi[d],          0);
  endtask

  // Issues one request at the current negedge and checks every cycle up to the
  // response handshake; strobeCyc=0 means no strobe expected.
  task automatic applyStimulus(input int d, input string tag, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int strobeCyc, input int rspCyc,
                               input logic [31:0] expRdata, input logic expErr,
                               input int stall, output int strobeAt);
    strobeAt = -1;
    checkOutput({tag, "/reqReady"}, 32'(reqReady[d]), 1);
    reqValid[d] = 1'b1;
    reqWr[d]    = wr;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    rspReady[d] = (stall == 0);
    if (wr && strobeCyc != 0) sb[d][addr[9:2]] = wdata;
    for (int c = 1; c <= rspCyc; c++) begin
      @(negedge clk);
      reqValid[d] = 1'b0;
      reqAddr[d]  = 32'hDEAD_BEEC;
      reqWdata[d] = 32'hBAD0_BAD0;
      checkOutput({tag, "/we"}, 32'(decWe[d]), 32'(wr && c == strobeCyc));
      checkOutput({tag, "/re"}, 32'(decRe[d]), 32'(!wr && c == strobeCyc));
      checkOutput({tag, "/rspValid"}, 32'(rspValid[d]), 32'(c == rspCyc));
      if (c == strobeCyc) begin
        strobeAt = cyc;
        checkOutput({tag, "/addr"}, decAddr[d], addr);
        if (wr) checkOutput({tag, "/di"}, decDi[d], wdata);
      end
    end
    checkOutput({tag, "/rdata"}, rspRdata[d], expRdata);
    checkOutput({tag, "/err"}, 32'(rspErr[d]), 32'(expErr));
    checkOutput({tag, "/reqReadyBusy"}, 32'(reqReady[d]), 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput({tag, "/holdValid"}, 32'(rspValid[d]), 1);
      checkOutput({tag, "/holdRdata"}, rspRdata[d], expRdata);
      checkOutput({tag, "/holdErr"}, 32'(rspErr[d]), 32'(expErr));
      checkOutput({tag, "/holdReady"}, 32'(reqReady[d]), 0);
      checkOutput({tag, "/holdStrobe"}, 32'(decRe[d] | decWe[d]), 0);
    end
    rspReady[d] = 1'b1;
    @(negedge clk);
    checkOutput({tag, "/rspDone"}, 32'(rspValid[d]), 0);
    checkOutput({tag, "/readyAgain"}, 32'(reqReady[d]), 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, t1, t2, t3, at;
    vecCount  = 0;
    missCount = 0;
    for (int d = 0; d < 2; d++) begin
      rstN[d]     = 1'b0;
      reqValid[d] = 1'b0;
      reqWr[d]    = 1'b0;
      reqAddr[d]  = 32'd0;
      reqWdata[d] = 32'd0;
      rspReady[d] = 1'b0;
      for (int i = 0; i < 256; i++) sb[d][i] = initWord(i);
    end

    repeat (3) @(negedge clk);
    checkResetOutputs(0, "rstA");
    checkResetOutputs(1, "rstB");
    rstN[0] = 1'b1;
    rstN[1] = 1'b1;
    @(negedge clk);
    checkOutput("rdyAfterRstA", 32'(reqReady[0]), 1);
    checkOutput("rdyAfterRstB", 32'(reqReady[1]), 1);

    applyStimulus(0, "wr40",  1'b1, 32'h40,  32'hA5A5_5A5A, 1, 2, 32'd0,         1'b0, 0, at);
    applyStimulus(0, "rd100", 1'b0, 32'h100, 32'd0,         1, 3, 32'h1234_5678, 1'b0, 0, at);
    applyStimulus(0, "bp40",  1'b0, 32'h40,  32'd0,         1, 3, 32'hA5A5_5A5A, 1'b0, 5, at);
    applyStimulus(0, "misRd", 1'b0, 32'h42,  32'd0,         0, 1, 32'd0,         1'b1, 0, at);
    applyStimulus(0, "misWr", 1'b1, 32'h43,  32'h0000_FFFF, 0, 1, 32'd0,         1'b1, 0, at);

    applyStimulus(0, "s0", 1'b1, 32'h80, 32'h1111_2222, 1, 2, 32'd0,     1'b0, 0, t0);
    applyStimulus(0, "s1", 1'b0, 32'h80, 32'd0,         1, 3, sb[0][32], 1'b0, 0, t1);
    applyStimulus(0, "s2", 1'b1, 32'h84, 32'h3333_4444, 1, 2, 32'd0,     1'b0, 0, t2);
    applyStimulus(0, "s3", 1'b0, 32'h84, 32'd0,         1, 3, sb[0][33], 1'b0, 0, t3);
    checkOutput("gapWr0", 32'(t1 - t0), 3);
    checkOutput("gapRd1", 32'(t2 - t1), 4);
    checkOutput("gapWr2", 32'(t3 - t2), 3);
    checkOutput("streamRd80", sb[0][32], 32'h1111_2222);

    applyStimulus(1, "bMis42", 1'b0, 32'h42,  32'd0, 1, 6, sb[1][16],     1'b0, 0, at);
    applyStimulus(1, "bRd100", 1'b0, 32'h100, 32'd0, 1, 6, 32'h1234_5678, 1'b0, 0, at);

    checkOutput("midRst/ready", 32'(reqReady[1]), 1);
    reqValid[1] = 1'b1;
    reqWr[1]    = 1'b0;
    reqAddr[1]  = 32'h100;
    rspReady[1] = 1'b1;
    @(negedge clk);
    reqValid[1] = 1'b0;
    checkOutput("midRst/re", 32'(decRe[1]), 1);
    @(negedge clk);
    @(negedge clk);
    rstN[1] = 1'b0;
    #1;
    checkResetOutputs(1, "midRst");
    @(negedge clk);
    rstN[1] = 1'b1;
    @(negedge clk);
    checkOutput("postRst/ready", 32'(reqReady[1]), 1);
    for (int k = 0; k < 8; k++) begin
      checkOutput("postRst/rspValid", 32'(rspValid[1]), 0);
      checkOutput("postRst/strobe", 32'(decRe[1] | decWe[1]), 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
